rv32i_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core on the DE2 board.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the instruction/data memory request handshakes.
- Generates the IR-load, PC-write and register-file-write strobes, using the instruction decoder's control outputs (we, jmpe, be, doe, mwe) plus a branch-compare result.
- Provides run/single-step control, an illegal-opcode trap, a memory-timeout error, and cycle/instret counters.

---
 rtl/rv32i_mc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle sequencer for the RV32I core: FETCH/DECODE/EXEC/MEM/WB
// stepping, memory handshakes, run/step control, traps and counters.
module rv32i_mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_load,
    input  logic        dec_we,
    input  logic        dec_doe,
    input  logic        dec_mwe,
    input  logic        dec_jmpe,
    input  logic        dec_be,
    input  logic        dec_illegal,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  state,
    output logic [1:0]  trap,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    state_e          state_q, state_d;
    logic [1:0]      trap_q, trap_d;
    logic            step_mode_q, step_mode_d;
    logic [TO_W-1:0] to_q, to_d, to_inc;
    logic [31:0]     cycle_q, cycle_d;
    logic [31:0]     instret_q, instret_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            trap_q      <= 2'b00;
            step_mode_q <= 1'b0;
            to_q        <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            trap_q      <= trap_d;
            step_mode_q <= step_mode_d;
            to_q        <= to_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
        end
    end

    assign to_inc = to_q + TO_ONE;

    always_comb begin
        state_d     = state_q;
        trap_d      = trap_q;
        step_mode_d = step_mode_q;
        to_d        = to_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;

        if (state_q != S_IDLE && state_q != S_HALT)
            cycle_d = cycle_q + 32'd1;

        unique case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d     = S_FETCH;
                    step_mode_d = ~run;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (to_inc == TO_MAX) begin
                    state_d = S_HALT;
                    trap_d  = 2'b10;
                end else begin
                    to_d = to_inc;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d = S_HALT;
                    trap_d  = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = dec_doe ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mwe;
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (to_inc == TO_MAX) begin
                    state_d = S_HALT;
                    trap_d  = 2'b11;
                end else begin
                    to_d = to_inc;
                end
            end
            S_WB: begin
                pc_we     = 1'b1;
                rf_we     = dec_we & ~dec_mwe;
                instret_d = instret_q + 32'd1;
                if (dec_jmpe)
                    pc_sel = 2'b01;
                else if (dec_be && br_taken)
                    pc_sel = 2'b10;
                if (step_mode_q || !run) begin
                    state_d     = S_IDLE;
                    step_mode_d = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // every state entry restarts the wait budget
        if (state_d != state_q)
            to_d = '0;
    end

    assign state     = state_q;
    assign trap      = trap_q;
    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl with programmable-latency
// instruction/data memory responders.
module tb_rv32i_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step;
    logic        imem_req, imem_ack, ir_load;
    logic        dec_we, dec_doe, dec_mwe, dec_jmpe, dec_be, dec_illegal;
    logic        br_taken;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        rf_we, pc_we;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [1:0]  trap;
    logic [31:0] cycle_cnt, instret;

    int errs = 0;
    int checks = 0;
    int ilat = 0;
    int dlat = 0;
    int iw = 0;
    int dw = 0;

    always #5 clk = ~clk;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
        .dec_we(dec_we), .dec_doe(dec_doe), .dec_mwe(dec_mwe),
        .dec_jmpe(dec_jmpe), .dec_be(dec_be), .dec_illegal(dec_illegal),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .state(state), .trap(trap),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    // ack after 'lat' waited cycles of an asserted request
    always @(posedge clk) begin
        iw <= imem_req ? iw + 1 : 0;
        dw <= dmem_req ? dw + 1 : 0;
    end
    assign imem_ack = imem_req && (iw >= ilat);
    assign dmem_ack = dmem_req && (dw >= dlat);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_dec(input logic we, input logic doe, input logic mwe,
                           input logic jmpe, input logic be,
                           input logic ill, input logic bt);
        dec_we = we; dec_doe = doe; dec_mwe = mwe; dec_jmpe = jmpe;
        dec_be = be; dec_illegal = ill; br_taken = bt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic do_step(output int ncyc, output int ndreq,
                           output int ndwe, output int nrf,
                           output int npc, output logic [1:0] sel);
        ncyc = 0; ndreq = 0; ndwe = 0; nrf = 0; npc = 0; sel = 2'b11;
        step = 1'b1;
        cyc();
        step = 1'b0;
        while (state != 3'd0 && ncyc < 50) begin
            ncyc++;
            if (dmem_req) ndreq++;
            if (dmem_req && dmem_we) ndwe++;
            if (rf_we) nrf++;
            if (pc_we) begin
                npc++;
                sel = pc_sel;
            end
            cyc();
        end
    endtask

    int nc, ndr, ndw, nrf, npc, nreq, bound;
    logic [1:0] sel;
    logic [31:0] c0, r0;
    logic [2:0] seq [4];

    initial begin
        seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd3; seq[3] = 3'd5;
        run = 1'b0; step = 1'b0; rst_n = 1'b0;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        check("rst_state", 32'(state), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);

        // free-running ADDI stream, run dropped in the 10th WB
        rst_n = 1'b1;
        run = 1'b1;
        cyc();
        for (int i = 0; i < 40; i++) begin
            check("addi_state", 32'(state), 32'(seq[i % 4]));
            check("addi_pc_we", 32'(pc_we), 32'(i % 4 == 3));
            check("addi_rf_we", 32'(rf_we), 32'(i % 4 == 3));
            if (i % 4 == 3) check("addi_pc_sel", 32'(pc_sel), 32'd0);
            if (i == 39) run = 1'b0;
            cyc();
        end
        check("addi_idle", 32'(state), 32'd0);
        check("addi_instret", instret, 32'd10);
        check("addi_cycle", cycle_cnt, 32'd40);

        // load with 3 wait cycles
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dlat = 3;
        c0 = cycle_cnt; r0 = instret;
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("ld_cycles", 32'(nc), 32'd8);
        check("ld_dmem_req", 32'(ndr), 32'd4);
        check("ld_dmem_we", 32'(ndw), 32'd0);
        check("ld_rf_we", 32'(nrf), 32'd1);
        check("ld_pc_we", 32'(npc), 32'd1);
        check("ld_instret", instret, r0 + 32'd1);
        check("ld_cycle_cnt", cycle_cnt, c0 + 32'd8);

        // store: rf_we masked even with dec_we high
        set_dec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        dlat = 0;
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("st_cycles", 32'(nc), 32'd5);
        check("st_dmem_we", 32'(ndw), 32'd1);
        check("st_rf_we", 32'(nrf), 32'd0);

        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("bt_cycles", 32'(nc), 32'd4);
        check("bt_pc_sel", 32'(sel), 32'd2);
        check("bt_rf_we", 32'(nrf), 32'd0);

        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("bn_pc_sel", 32'(sel), 32'd0);

        set_dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("jal_pc_sel", 32'(sel), 32'd1);
        check("jal_rf_we", 32'(nrf), 32'd1);

        // fetch with 2 wait cycles stretches the instruction to 6
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ilat = 2;
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("fw_cycles", 32'(nc), 32'd6);
        ilat = 0;

        // illegal opcode traps and freezes
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("ill_fetch", 32'(state), 32'd1);
        cyc();
        check("ill_decode", 32'(state), 32'd2);
        cyc();
        check("ill_state", 32'(state), 32'd6);
        check("ill_trap", 32'(trap), 32'd1);
        c0 = cycle_cnt; r0 = instret;
        run = 1'b1;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) nreq++;
            cyc();
        end
        run = 1'b0;
        check("ill_no_req", 32'(nreq), 32'd0);
        check("ill_cycle_frz", cycle_cnt, c0);
        check("ill_inst_frz", instret, r0);
        check("ill_sticky", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        check("ill_rst_state", 32'(state), 32'd0);
        check("ill_rst_trap", 32'(trap), 32'd0);
        cyc();
        rst_n = 1'b1;

        // imem never acks -> 4 request cycles then trap
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ilat = 1000;
        step = 1'b1;
        cyc();
        step = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) nreq++;
            cyc();
        end
        check("ito_req_cycles", 32'(nreq), 32'd4);
        check("ito_state", 32'(state), 32'd6);
        check("ito_trap", 32'(trap), 32'd2);
        ilat = 0;
        do_reset();

        // dmem never acks -> dmem timeout trap
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dlat = 1000;
        step = 1'b1;
        cyc();
        step = 1'b0;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            if (dmem_req) nreq++;
            cyc();
        end
        check("dto_req_cycles", 32'(nreq), 32'd4);
        check("dto_trap", 32'(trap), 32'd3);
        do_reset();

        // single step retires exactly one instruction
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_step(nc, ndr, ndw, nrf, npc, sel);
        check("step_instret", instret, 32'd1);
        check("step_idle", 32'(state), 32'd0);

        // async reset in the middle of MEM
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step = 1'b1;
        cyc();
        step = 1'b0;
        bound = 0;
        while (state != 3'd4 && bound < 10) begin
            bound++;
            cyc();
        end
        check("mr_in_mem", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req_drop", 32'(dmem_req), 32'd0);
        check("mr_state", 32'(state), 32'd0);
        cyc();
        rst_n = 1'b1;
        dlat = 0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
